// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the MEM-stage access sequencer and the SRAM controller.
//   - FSM state encodings
//   - default wait-state count, data and address widths
//   - request-legality helper
package mem_access_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int unsigned WAIT_STATES_DEF = 3;
    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned ADDR_W_DEF      = 16;
    localparam int unsigned CNT_W           = 3;

    // A request is illegal if it is both a load and a store, or misaligned.
    function automatic logic req_illegal(input logic r_en, input logic w_en, input logic addr_lsb);
        return (r_en & w_en) | addr_lsb;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_wait_counter.sv
// wait_counter: loadable down-counter that stops at zero.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   load          load i_val into the counter (has priority over dec)
//   load_val      value to load
//   dec           decrement by one; ignored once the count is zero
//   zero          count is zero
module wait_counter
    import mem_access_sequencer_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] r_cnt;

    // Saturating at zero means the count can never wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: turns a one-cycle load/store request into a
// fixed-length SRAM access and freezes the pipeline until it completes.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   mem_r_en, mem_w_en  load / store request from EXE/MEM
//   alu_addr, st_val    byte address and store data
//   sram_rdata          read data from the SRAM controller
//   mem_cmd, store_en   access strobe and direction to the controller
//   mem_addr, data_in   word address and store data to the controller
//   freeze              combinational pipeline stall
//   ld_data, ld_valid   captured load data and its one-cycle valid pulse
//   err                 sticky illegal-request flag
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_STATES = WAIT_STATES_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] st_val,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              mem_cmd,
    output logic              store_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] data_in,
    output logic              freeze,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_valid,
    output logic              err
);

    state_t r_state;
    logic   w_req;
    logic   w_load;
    logic   w_dec;
    logic   w_zero;

    assign w_req  = mem_r_en | mem_w_en;
    assign w_load = (r_state == ST_IDLE) & w_req;
    assign w_dec  = (r_state == ST_ACCESS);

    wait_counter #(
        .W (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (CNT_W'(WAIT_STATES)),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    // Stall from the cycle the request is seen until the last strobe cycle.
    assign freeze = rst & (w_load | (r_state == ST_ACCESS));

    // Sequencer FSM with registered controller outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            mem_cmd  <= 1'b0;
            store_en <= 1'b0;
            mem_addr <= '0;
            data_in  <= '0;
            ld_data  <= '0;
            ld_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            ld_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state  <= ST_ACCESS;
                        mem_cmd  <= 1'b1;
                        // Simultaneous load+store resolves to a store.
                        store_en <= mem_w_en;
                        mem_addr <= {1'b0, alu_addr[ADDR_W-1:1]};
                        data_in  <= st_val;
                        if (req_illegal(mem_r_en, mem_w_en, alu_addr[0])) begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_zero) begin
                        r_state <= ST_DONE;
                        mem_cmd <= 1'b0;
                        if (!store_en) begin
                            ld_data  <= sram_rdata;
                            ld_valid <= 1'b1;
                        end
                    end
                end
                // The same instruction is still in MEM here, so no new request.
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    mem_cmd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

    localparam int WS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [15:0] alu_addr;
    logic [15:0] st_val;
    logic [15:0] sram_rdata;
    logic        mem_cmd;
    logic        store_en;
    logic [15:0] mem_addr;
    logic [15:0] data_in;
    logic        freeze;
    logic [15:0] ld_data;
    logic        ld_valid;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_cmd_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_sequencer #(
        .WAIT_STATES (WS),
        .DATA_W      (16),
        .ADDR_W      (16)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .alu_addr   (alu_addr),
        .st_val     (st_val),
        .sram_rdata (sram_rdata),
        .mem_cmd    (mem_cmd),
        .store_en   (store_en),
        .mem_addr   (mem_addr),
        .data_in    (data_in),
        .freeze     (freeze),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .err        (err)
    );

    typedef struct {
        string       name;
        logic        r;
        logic        w;
        logic [15:0] addr;
        logic [15:0] st;
        logic [15:0] rdata;
        logic [15:0] exp_addr;
        logic [15:0] exp_din;
        logic        exp_se;
        logic        exp_ld;
        logic [15:0] exp_ldd;
        logic        exp_err;
        logic        b2b;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle k=0 is the cycle the request is first presented in IDLE.
    task automatic run_vec(input vec_t v);
        logic e_frz, e_cmd, e_lv;
        for (int k = 0; k <= WS + 2; k++) begin
            tick();
            rst        = 1'b1;
            mem_r_en   = v.r;
            mem_w_en   = v.w;
            alu_addr   = v.addr;
            st_val     = v.st;
            sram_rdata = (k == WS + 2) ? 16'h0000 : ((k == WS + 1) ? v.rdata : ~v.rdata);
            #1;
            e_frz = (k <= WS + 1);
            e_cmd = (k >= 1) && (k <= WS + 1);
            e_lv  = (k == WS + 2) && v.exp_ld;
            check({v.name, " freeze/cmd/ldv"}, 64'({freeze, mem_cmd, ld_valid}), 64'({e_frz, e_cmd, e_lv}));
            if (e_cmd) begin
                check({v.name, " mem_addr"}, 64'(mem_addr), 64'(v.exp_addr));
                check({v.name, " store_en"}, 64'(store_en), 64'(v.exp_se));
                check({v.name, " data_in"},  64'(data_in),  64'(v.exp_din));
            end
            if (k == 1) begin
                if (v.b2b) check({v.name, " b2b spacing"}, 64'(cyc - last_cmd_cyc), 64'(WS + 3));
                last_cmd_cyc = cyc;
            end
            if (k == WS + 2) begin
                check({v.name, " ld_data"}, 64'(ld_data), 64'(v.exp_ldd));
                check({v.name, " err"},     64'(err),     64'(v.exp_err));
            end
        end
    endtask

    task automatic idle_cycle();
        tick();
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        #1;
        check("idle freeze/cmd/ldv", 64'({freeze, mem_cmd, ld_valid}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        //          name          r     w     addr      st        rdata     e_addr    e_din     se    ld    ldd       err   b2b
        vecs[0] = '{"load24",     1'b1, 1'b0, 16'h0024, 16'h0000, 16'hBEEF, 16'h0012, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0};
        vecs[1] = '{"store100",   1'b0, 1'b1, 16'h0100, 16'h1234, 16'hAAAA, 16'h0080, 16'h1234, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b1};
        vecs[2] = '{"loadFFFE",   1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{"store8000",  1'b0, 1'b1, 16'h8000, 16'hFFFF, 16'h5555, 16'h4000, 16'hFFFF, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b1};
        vecs[4] = '{"both_rw",    1'b1, 1'b1, 16'h0010, 16'h5A5A, 16'h1111, 16'h0008, 16'h5A5A, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[5] = '{"odd3",       1'b1, 1'b0, 16'h0003, 16'h0000, 16'h7777, 16'h0001, 16'h0000, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b1};
        vecs[6] = '{"sticky_err", 1'b1, 1'b0, 16'h0044, 16'h0000, 16'h0F0F, 16'h0022, 16'h0000, 1'b0, 1'b1, 16'h0F0F, 1'b1, 1'b0};

        // Reset held with a pending load: nothing may happen.
        rst        = 1'b0;
        mem_r_en   = 1'b1;
        mem_w_en   = 1'b0;
        alu_addr   = 16'h0024;
        st_val     = 16'h1234;
        sram_rdata = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset ctl", 64'({freeze, mem_cmd, store_en, ld_valid, err}), 64'(0));
            check("reset data", 64'({mem_addr, data_in, ld_data}), 64'(0));
        end

        // Reset release coincides with cycle 0 of the first vector.
        for (int i = 0; i < 7; i++) begin
            if (i > 0 && !vecs[i].b2b) idle_cycle();
            run_vec(vecs[i]);
        end
        idle_cycle();

        // Reset in cycle 2 of a load aborts it and clears err.
        tick();
        mem_r_en   = 1'b1;
        alu_addr   = 16'h0030;
        st_val     = 16'h0000;
        sram_rdata = 16'h2222;
        #1;
        check("abort c0 freeze", 64'(freeze), 64'(1));
        tick();
        check("abort c1 mem_cmd", 64'(mem_cmd), 64'(1));
        tick();
        rst = 1'b0;
        #1;
        check("abort c2 freeze/cmd", 64'({freeze, mem_cmd}), 64'(1));
        tick();
        rst      = 1'b1;
        mem_r_en = 1'b0;
        #1;
        check("abort c3 freeze/cmd/err", 64'({freeze, mem_cmd, err}), 64'(0));
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort quiet", 64'({freeze, mem_cmd, ld_valid}), 64'(0));
        end

        v = '{"post_abort", 1'b1, 1'b0, 16'h0050, 16'h0000, 16'hC3C3, 16'h0028, 16'h0000, 1'b0, 1'b1, 16'hC3C3, 1'b0, 1'b0};
        run_vec(v);
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
